serial_frame_rx: RTL and testbench



---
 rtl/serial_link_pkg.sv | 28 ++
 rtl/serial_frame_rx_sipo_shift.sv | 39 +++
 rtl/serial_frame_rx.sv | 128 ++++++++++++
 tb/tb_serial_frame_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_link_pkg : frame constants and FSM states for the serial link |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int DEFAULT_WORD_W = 4;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  localparam int DATA_BITS = 2 * DEFAULT_WORD_W;

  function automatic int data_bits(input int word_w);
    return 2 * word_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_rx_sipo_shift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sipo_shift : serial-in parallel-out register with running parity    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sipo_shift #(
  parameter int N = 8
) (
  input  logic         ck,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [N-1:0] o_data,
  output logic         o_parity
);

  logic [N-1:0] r_data;
  logic         r_par;

  // Clear wins over shift so a new frame always starts from a clean slate.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_par  <= 1'b0;
    end else if (i_clr) begin
      r_data <= '0;
      r_par  <= 1'b0;
    end else if (i_en) begin
      r_data <= {r_data[N-2:0], i_bit};
      r_par  <= r_par ^ i_bit;
    end
  end

  assign o_data   = r_data;
  assign o_parity = r_par;

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_frame_rx : recovers two words from the serial line, checks    |
// | parity and stop bit, counts bad frames.            Rev 1.0           |
// +----------------------------------------------------------------------+
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int ERR_W  = 8
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              sin,
  output logic [WORD_W-1:0] dout_a,
  output logic [WORD_W-1:0] dout_b,
  output logic              vo,
  output logic              ok,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int NBITS = data_bits(WORD_W);
  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(NBITS - 1);

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_bitcnt;
  logic               r_par_good;
  logic               r_vo;
  logic               r_ok;
  logic [WORD_W-1:0]  r_dout_a;
  logic [WORD_W-1:0]  r_dout_b;
  logic [ERR_W-1:0]   r_err_cnt;

  logic               w_clr;
  logic               w_shift;
  logic               w_done;
  logic [NBITS-1:0]   w_shreg;
  logic               w_parity;
  logic               w_frame_good;

  sipo_shift #(.N(NBITS)) u_sipo (
    .ck       (ck),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_en     (w_shift),
    .i_bit    (sin),
    .o_data   (w_shreg),
    .o_parity (w_parity)
  );

  always_ff @(posedge ck or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_clr      = 1'b0;
    w_shift    = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (sin == START_BIT) begin
          w_state_nx = DATA;
          w_clr      = 1'b1;
        end
      end
      DATA: begin
        w_shift = 1'b1;
        if (r_bitcnt == C_LAST_BIT) w_state_nx = PARITY;
      end
      PARITY: w_state_nx = STOP;
      STOP: begin
        // The stop-bit sample is never reinterpreted as a start bit.
        w_done     = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset)        r_bitcnt <= '0;
    else if (w_clr)   r_bitcnt <= '0;
    else if (w_shift) r_bitcnt <= r_bitcnt + 1'b1;
  end

  // Even parity: the parity bit must equal the XOR of the data bits.
  always_ff @(posedge ck or posedge reset) begin
    if (reset)                  r_par_good <= 1'b0;
    else if (r_state == PARITY) r_par_good <= (w_parity == sin);
  end

  assign w_frame_good = r_par_good && (sin == STOP_BIT);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_vo      <= 1'b0;
      r_ok      <= 1'b0;
      r_dout_a  <= '0;
      r_dout_b  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_vo <= w_done;
      if (w_done) begin
        r_ok <= w_frame_good;
        if (w_frame_good) begin
          r_dout_a <= w_shreg[NBITS-1:WORD_W];
          r_dout_b <= w_shreg[WORD_W-1:0];
        end else if (r_err_cnt != {ERR_W{1'b1}}) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign dout_a  = r_dout_a;
  assign dout_b  = r_dout_b;
  assign vo      = r_vo;
  assign ok      = r_ok;
  assign busy    = (r_state != IDLE);
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_frame_rx : self-checking bench for serial_frame_rx         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_serial_frame_rx;

  logic       ck = 1'b0;
  logic       reset;
  logic       sin;
  logic [3:0] dout_a, dout_b;
  logic       vo, ok, busy;
  logic [7:0] err_cnt;

  serial_frame_rx #(.WORD_W(4), .ERR_W(8)) dut (
    .ck(ck), .reset(reset), .sin(sin),
    .dout_a(dout_a), .dout_b(dout_b), .vo(vo), .ok(ok),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic       ok;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] err;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    bit         pflip;
    bit         sbad;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_vo_cyc = 0;
  int   prev_vo_cyc = 0;
  logic prev_vo = 1'b0;

  logic [3:0] m_a = 4'h0, m_b = 4'h0;
  logic [7:0] m_err = 8'h0;

  always @(posedge ck) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (vo === 1'b1) begin
      chk("vo_width", 32'(prev_vo), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_vo: got vo=1 expected no frame (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ok",      32'(ok),      32'(e.ok));
        chk("dout_a",  32'(dout_a),  32'(e.a));
        chk("dout_b",  32'(dout_b),  32'(e.b));
        chk("err_cnt", 32'(err_cnt), 32'(e.err));
      end
      prev_vo_cyc = last_vo_cyc;
      last_vo_cyc = cyc;
    end
    prev_vo = vo;
  end

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge ck);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b,
                            input bit pflip, input bit sbad);
    logic [7:0] d;
    d = {a, b};
    send_bit(1'b1);
    for (int k = 7; k >= 0; k--) send_bit(d[k]);
    send_bit((^d) ^ pflip);
    send_bit(sbad);
    sin = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input bit good);
    if (good) begin
      m_a = a;
      m_b = b;
    end else if (m_err != 8'hFF) begin
      m_err = m_err + 8'h1;
    end
    sb.push_back('{ok: good, a: m_a, b: m_b, err: m_err});
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 30) begin
      @(posedge ck);
      #1;
      guard++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'hC, 4'hA, 0, 0, '{1'b1, 4'hC, 4'hA, 8'd0}};
    tbl[1] = '{4'hC, 4'hA, 1, 0, '{1'b0, 4'hC, 4'hA, 8'd1}};
    tbl[2] = '{4'hA, 4'h5, 0, 1, '{1'b0, 4'hC, 4'hA, 8'd2}};
    tbl[3] = '{4'hA, 4'h5, 0, 0, '{1'b1, 4'hA, 4'h5, 8'd2}};
    tbl[4] = '{4'h3, 4'hC, 0, 0, '{1'b1, 4'h3, 4'hC, 8'd2}};
    tbl[5] = '{4'hF, 4'h0, 1, 0, '{1'b0, 4'h3, 4'hC, 8'd3}};
    tbl[6] = '{4'h0, 4'h0, 0, 0, '{1'b1, 4'h0, 4'h0, 8'd3}};
    tbl[7] = '{4'hF, 4'hF, 0, 0, '{1'b1, 4'hF, 4'hF, 8'd3}};

    reset = 1'b1;
    sin   = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    chk("rst_vo",     32'(vo),     32'd0);
    chk("rst_ok",     32'(ok),     32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_err",    32'(err_cnt), 32'd0);
    reset = 1'b0;
    send_bit(1'b0);

    for (int i = 0; i < 8; i++) begin
      sb.push_back(tbl[i].exp);
      send_frame(tbl[i].a, tbl[i].b, tbl[i].pflip, tbl[i].sbad);
      send_bit(1'b0);
      send_bit(1'b0);
    end
    wait_drain("table_drain");
    m_a = tbl[7].exp.a;
    m_b = tbl[7].exp.b;
    m_err = tbl[7].exp.err;

    // Bad stop bit followed by idle: the 1 in the stop slot must not start a frame.
    push_exp(4'h5, 4'hA, 1'b0);
    send_frame(4'h5, 4'hA, 0, 1);
    chk("stop_err_busy", 32'(busy), 32'd0);
    repeat (12) send_bit(1'b0);
    chk("stop_err_idle_busy", 32'(busy), 32'd0);
    wait_drain("stop_err_drain");

    push_exp(4'hA, 4'h5, 1'b1);
    push_exp(4'h3, 4'hC, 1'b1);
    send_frame(4'hA, 4'h5, 0, 0);
    send_frame(4'h3, 4'hC, 0, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    wait_drain("b2b_drain");
    chk("b2b_spacing", 32'(last_vo_cyc - prev_vo_cyc), 32'd11);

    // Reset after the fourth data bit of a frame.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_dout_a", 32'(dout_a), 32'd0);
    chk("mid_rst_dout_b", 32'(dout_b), 32'd0);
    chk("mid_rst_vo",     32'(vo),     32'd0);
    chk("mid_rst_ok",     32'(ok),     32'd0);
    chk("mid_rst_busy",   32'(busy),   32'd0);
    chk("mid_rst_err",    32'(err_cnt), 32'd0);
    sin = 1'b0;
    m_a = 4'h0;
    m_b = 4'h0;
    m_err = 8'h0;
    repeat (2) @(posedge ck);
    #3;
    reset = 1'b0;
    @(posedge ck);
    #1;
    repeat (12) send_bit(1'b0);
    push_exp(4'hC, 4'hA, 1'b1);
    send_frame(4'hC, 4'hA, 0, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    wait_drain("post_rst_drain");

    for (int i = 0; i < 260; i++) begin
      logic [7:0] v;
      v = 8'(i);
      push_exp(v[3:0], ~v[7:4], 1'b0);
      send_frame(v[3:0], ~v[7:4], 1, 0);
    end
    send_bit(1'b0);
    wait_drain("sat_drain");
    chk("sat_err", 32'(err_cnt), 32'd255);
    push_exp(4'h6, 4'h9, 1'b1);
    send_frame(4'h6, 4'h9, 0, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    wait_drain("sat_good_drain");
    chk("sat_err_hold", 32'(err_cnt), 32'd255);
    chk("sat_ok", 32'(ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
